// File: rtl/nn_pkg.sv
// rtl/nn_pkg.sv - shared widths, data types and MAC accumulator state encoding
package nn_pkg;

    localparam int DEFAULT_DATA_WIDTH = 16;
    localparam int DEFAULT_ACC_WIDTH  = 32;

    typedef logic signed [DEFAULT_DATA_WIDTH-1:0] data_t;
    typedef logic signed [DEFAULT_ACC_WIDTH-1:0]  acc_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        DRAIN  = 2'd2,
        OUTPUT = 2'd3
    } mac_state_t;

endpackage

// File: rtl/mac_multiplier.sv
// rtl/mac_multiplier.sv - registered signed multiply with valid/last pass-through
//
// Stage 1 of the MAC pipeline: one cycle after valid_in, product_out holds
// a_in*b_in at full 2*DATA_WIDTH signed precision.
//   clk_in, rst_n_in     : clock, synchronous active-low reset
//   a_in, b_in           : signed operands
//   valid_in, last_in    : operand qualifiers
//   product_out          : registered signed product
//   valid_out, last_out  : qualifiers aligned with product_out
module mac_multiplier
    import nn_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                           clk_in,
    input  logic                           rst_n_in,
    input  logic signed [DATA_WIDTH-1:0]   a_in,
    input  logic signed [DATA_WIDTH-1:0]   b_in,
    input  logic                           valid_in,
    input  logic                           last_in,
    output logic signed [2*DATA_WIDTH-1:0] product_out,
    output logic                           valid_out,
    output logic                           last_out
);

    localparam int PW = 2 * DATA_WIDTH;

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            product_out <= '0;
            valid_out   <= 1'b0;
            last_out    <= 1'b0;
        end else begin
            valid_out <= valid_in;
            last_out  <= valid_in & last_in;
            if (valid_in) begin
                product_out <= PW'(a_in) * PW'(b_in);
            end
        end
    end

endmodule

// File: rtl/neuron_mac_accumulator.sv
// rtl/neuron_mac_accumulator.sv - streaming signed dot-product accumulator for one neuron
//
// Accepts (data, weight) pairs, multiplies them in mac_multiplier and sums the
// products into a wrapping ACC_WIDTH accumulator; the finished sum is held on
// sum_out with sum_valid_out until sum_ready_in.
//   clk_in, rst_n_in          : clock, synchronous active-low reset
//   bias_in                   : initial accumulator bias (NEURON_MAC_BIAS_EN only)
//   data_in, weight_in        : signed pair
//   in_valid_in, in_last_in   : pair qualifiers
//   in_ready_out              : pair accepted when high together with in_valid_in
//   sum_out, sum_valid_out    : dot product and its valid
//   sum_ready_in              : downstream accepts the sum
//   overrun_out               : vector closed by MAX_LEN rather than in_last_in
// Optional feature macro: NEURON_MAC_BIAS_EN adds bias_in, sampled on the first
// accepted pair of each vector.
module neuron_mac_accumulator
    import nn_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ACC_WIDTH  = DEFAULT_ACC_WIDTH,
    parameter int MAX_LEN    = 1024
) (
    input  logic                         clk_in,
    input  logic                         rst_n_in,
`ifdef NEURON_MAC_BIAS_EN
    input  logic signed [ACC_WIDTH-1:0]  bias_in,
`endif
    input  logic signed [DATA_WIDTH-1:0] data_in,
    input  logic signed [DATA_WIDTH-1:0] weight_in,
    input  logic                         in_valid_in,
    input  logic                         in_last_in,
    output logic                         in_ready_out,
    output logic signed [ACC_WIDTH-1:0]  sum_out,
    output logic                         sum_valid_out,
    input  logic                         sum_ready_in,
    output logic                         overrun_out
);

    localparam int CW = $clog2(MAX_LEN + 1);

    mac_state_t state, state_nxt;

    logic [CW-1:0]                 count;
    logic signed [ACC_WIDTH-1:0]   acc;
    logic signed [ACC_WIDTH-1:0]   acc_base;
    logic signed [ACC_WIDTH-1:0]   prod_ext;
    logic signed [2*DATA_WIDTH-1:0] p_product;
    logic                          p_valid;
    logic                          p_last;
    logic                          p_first;
    logic                          accept;
    logic                          at_max;
    logic                          vec_last;
    logic                          first_accept;

    assign accept       = in_valid_in & in_ready_out;
    assign first_accept = accept & (state == IDLE);
    // count is zero in IDLE, so this also covers MAX_LEN == 1 on the first pair.
    assign at_max       = (count == CW'(MAX_LEN - 1));
    assign vec_last     = in_last_in | at_max;
    assign prod_ext     = ACC_WIDTH'(p_product);
    assign sum_out      = acc;

    mac_multiplier #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_mult (
        .clk_in      (clk_in),
        .rst_n_in    (rst_n_in),
        .a_in        (data_in),
        .b_in        (weight_in),
        .valid_in    (accept),
        .last_in     (vec_last),
        .product_out (p_product),
        .valid_out   (p_valid),
        .last_out    (p_last)
    );

`ifdef NEURON_MAC_BIAS_EN
    logic signed [ACC_WIDTH-1:0] bias_q;

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            bias_q <= '0;
        end else if (first_accept) begin
            bias_q <= bias_in;
        end
    end

    assign acc_base = bias_q;
`else
    assign acc_base = '0;
`endif

    always_comb begin
        state_nxt     = state;
        in_ready_out  = 1'b0;
        sum_valid_out = 1'b0;
        case (state)
            IDLE, ACCUM: begin
                in_ready_out = 1'b1;
                if (accept) begin
                    state_nxt = vec_last ? DRAIN : ACCUM;
                end
            end
            DRAIN: begin
                // The last product lands in acc on this edge.
                if (p_valid && p_last) begin
                    state_nxt = OUTPUT;
                end
            end
            OUTPUT: begin
                sum_valid_out = 1'b1;
                if (sum_ready_in) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state       <= IDLE;
            count       <= '0;
            acc         <= '0;
            overrun_out <= 1'b0;
            p_first     <= 1'b0;
        end else begin
            state   <= state_nxt;
            // Tags the product now entering stage 1 as the first of its vector.
            p_first <= first_accept;

            if (accept) begin
                count <= count + CW'(1);
                if (at_max && !in_last_in) begin
                    overrun_out <= 1'b1;
                end
            end

            if (p_valid) begin
                acc <= p_first ? (acc_base + prod_ext) : (acc + prod_ext);
            end

            if (state == OUTPUT && sum_ready_in) begin
                acc         <= '0;
                count       <= '0;
                overrun_out <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_neuron_mac_accumulator.sv
// tb/tb_neuron_mac_accumulator.sv - self-checking bench for neuron_mac_accumulator
module tb_neuron_mac_accumulator;

    localparam int DW = 16;
    localparam int AW = 32;
    localparam int ML = 4;

    logic                 clk_in = 1'b0;
    logic                 rst_n_in;
    logic signed [DW-1:0] data_in;
    logic signed [DW-1:0] weight_in;
    logic                 in_valid_in;
    logic                 in_last_in;
    logic                 in_ready_out;
    logic signed [AW-1:0] sum_out;
    logic                 sum_valid_out;
    logic                 sum_ready_in;
    logic                 overrun_out;
`ifdef NEURON_MAC_BIAS_EN
    logic signed [AW-1:0] bias_in;
`endif

    always #5 clk_in = ~clk_in;

    neuron_mac_accumulator #(
        .DATA_WIDTH (DW),
        .ACC_WIDTH  (AW),
        .MAX_LEN    (ML)
    ) dut (
        .clk_in        (clk_in),
        .rst_n_in      (rst_n_in),
`ifdef NEURON_MAC_BIAS_EN
        .bias_in       (bias_in),
`endif
        .data_in       (data_in),
        .weight_in     (weight_in),
        .in_valid_in   (in_valid_in),
        .in_last_in    (in_last_in),
        .in_ready_out  (in_ready_out),
        .sum_out       (sum_out),
        .sum_valid_out (sum_valid_out),
        .sum_ready_in  (sum_ready_in),
        .overrun_out   (overrun_out)
    );

    typedef struct {
        logic [AW-1:0] sum;
        logic          ovr;
    } exp_t;

    exp_t   sb[$];
    int     n_tests = 0;
    int     n_fail  = 0;
    longint m_acc   = 0;
    longint m_bias  = 0;
    int     m_cnt   = 0;

    task automatic clear_model();
        m_acc = 0;
        m_cnt = 0;
    endtask

    // Drives one pair until accepted; updates the reference model on accept.
    task automatic drive_pair(input int d, input int w, input bit last, output bit ok);
        longint p;
        ok = 1'b0;
        data_in     = d[DW-1:0];
        weight_in   = w[DW-1:0];
        in_last_in  = last;
        in_valid_in = 1'b1;
`ifdef NEURON_MAC_BIAS_EN
        bias_in     = m_bias[AW-1:0];
`endif
        for (int i = 0; i < 20 && !ok; i++) begin
            ok = in_ready_out;
            @(posedge clk_in); #1;
        end
        in_valid_in = 1'b0;
        in_last_in  = 1'b0;
        if (ok) begin
            p     = longint'(d) * longint'(w);
            m_acc = (m_cnt == 0) ? (m_bias + p) : (m_acc + p);
            m_cnt++;
            if (last || m_cnt == ML) begin
                sb.push_back('{m_acc[AW-1:0], !last});
                clear_model();
            end
        end
    endtask

    task automatic wait_sum(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (sum_valid_out) ok = 1'b1;
            else begin @(posedge clk_in); #1; end
        end
    endtask

    task automatic get_exp(output exp_t e);
        if (sb.size() > 0) e = sb.pop_front();
        else e = '{'x, 1'bx};
    endtask

    task automatic test_reset();
        rst_n_in = 1'b0;
        repeat (2) @(posedge clk_in);
        #1;
        n_tests++; if (in_ready_out !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", in_ready_out); end
        n_tests++; if (sum_valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", sum_valid_out); end
        n_tests++; if (sum_out !== '0) begin n_fail++; $display("FAIL reset_sum got %0d want 0", sum_out); end
        n_tests++; if (overrun_out !== 1'b0) begin n_fail++; $display("FAIL reset_overrun got %b want 0", overrun_out); end
        rst_n_in = 1'b1;
        @(posedge clk_in); #1;
    endtask

    task automatic test_basic();
        bit ok, all_ok, hold_ok;
        exp_t e;
        sum_ready_in = 1'b0;
        all_ok = 1'b1;
        drive_pair(3, 4, 0, ok);  all_ok &= ok;
        drive_pair(-2, 5, 0, ok); all_ok &= ok;
        drive_pair(7, -1, 1, ok); all_ok &= ok;
        n_tests++; if (!all_ok) begin n_fail++; $display("FAIL basic_accept got 0 want 1"); end
        n_tests++; if (sum_valid_out !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid got %b want 0", sum_valid_out); end
        @(posedge clk_in); #1;
        n_tests++; if (sum_valid_out !== 1'b1) begin n_fail++; $display("FAIL basic_latency got %b want 1", sum_valid_out); end
        get_exp(e);
        n_tests++; if (sum_out !== e.sum) begin n_fail++; $display("FAIL basic_sum got %0d want %0d", sum_out, $signed(e.sum)); end
        hold_ok = 1'b1;
        repeat (3) begin
            @(posedge clk_in); #1;
            if (sum_valid_out !== 1'b1 || sum_out !== e.sum || in_ready_out !== 1'b0) hold_ok = 1'b0;
        end
        n_tests++; if (!hold_ok) begin n_fail++; $display("FAIL basic_hold got valid=%b sum=%0d want valid=1 sum=%0d", sum_valid_out, sum_out, $signed(e.sum)); end
        sum_ready_in = 1'b1;
        @(posedge clk_in); #1;
        n_tests++; if (sum_valid_out !== 1'b0 || in_ready_out !== 1'b1 || sum_out !== '0) begin
            n_fail++; $display("FAIL basic_release got valid=%b ready=%b sum=%0d want 0 1 0", sum_valid_out, in_ready_out, sum_out);
        end
    endtask

    task automatic test_single();
        bit ok;
        exp_t e;
        sum_ready_in = 1'b1;
        drive_pair(32767, 32767, 1, ok);
        wait_sum(ok);
        get_exp(e);
        n_tests++; if (!ok || sum_out !== e.sum) begin n_fail++; $display("FAIL single_sum got %0d want %0d", sum_out, $signed(e.sum)); end
        @(posedge clk_in); #1;
        drive_pair(1, -1, 1, ok);
        wait_sum(ok);
        get_exp(e);
        n_tests++; if (!ok || sum_out !== e.sum) begin n_fail++; $display("FAIL single_clean got %0d want %0d", sum_out, $signed(e.sum)); end
        @(posedge clk_in); #1;
    endtask

    task automatic test_overrun();
        bit ok, all_ok;
        exp_t e;
        sum_ready_in = 1'b0;
        all_ok = 1'b1;
        repeat (ML) begin drive_pair(1, 1, 0, ok); all_ok &= ok; end
        data_in = 16'sd1; weight_in = 16'sd1; in_last_in = 1'b0; in_valid_in = 1'b1;
        n_tests++; if (!all_ok || in_ready_out !== 1'b0) begin n_fail++; $display("FAIL ovr_stall got ready=%b want 0", in_ready_out); end
        @(posedge clk_in); #1;
        get_exp(e);
        n_tests++; if (sum_valid_out !== 1'b1 || sum_out !== e.sum) begin n_fail++; $display("FAIL ovr_sum got %0d valid=%b want %0d", sum_out, sum_valid_out, $signed(e.sum)); end
        n_tests++; if (overrun_out !== e.ovr) begin n_fail++; $display("FAIL ovr_flag got %b want %b", overrun_out, e.ovr); end
        n_tests++; if (in_ready_out !== 1'b0) begin n_fail++; $display("FAIL ovr_output_ready got %b want 0", in_ready_out); end
        sum_ready_in = 1'b1;
        @(posedge clk_in); #1;
        n_tests++; if (overrun_out !== 1'b0) begin n_fail++; $display("FAIL ovr_clear got %b want 0", overrun_out); end
        drive_pair(1, 1, 1, ok);
        wait_sum(ok);
        get_exp(e);
        n_tests++; if (!ok || sum_out !== e.sum || overrun_out !== e.ovr) begin
            n_fail++; $display("FAIL ovr_next got sum=%0d ovr=%b want sum=%0d ovr=%b", sum_out, overrun_out, $signed(e.sum), e.ovr);
        end
        @(posedge clk_in); #1;
    endtask

    task automatic test_wrap();
        bit ok;
        exp_t e;
        sum_ready_in = 1'b1;
        repeat (3) drive_pair(-32768, -32768, 0, ok);
        drive_pair(-32768, -32768, 1, ok);
        wait_sum(ok);
        get_exp(e);
        n_tests++; if (!ok || sum_out !== e.sum || overrun_out !== e.ovr) begin
            n_fail++; $display("FAIL wrap_sum got sum=%0d ovr=%b want sum=%0d ovr=%b", sum_out, overrun_out, $signed(e.sum), e.ovr);
        end
        @(posedge clk_in); #1;
    endtask

    task automatic test_reset_mid();
        bit ok, quiet;
        exp_t e;
        sum_ready_in = 1'b1;
        drive_pair(5, 5, 0, ok);
        drive_pair(6, 6, 0, ok);
        rst_n_in = 1'b0;
        clear_model();
        @(posedge clk_in); #1;
        n_tests++; if (in_ready_out !== 1'b1 || sum_valid_out !== 1'b0 || sum_out !== '0 || overrun_out !== 1'b0) begin
            n_fail++; $display("FAIL midrst_outputs got ready=%b valid=%b sum=%0d ovr=%b want 1 0 0 0", in_ready_out, sum_valid_out, sum_out, overrun_out);
        end
        rst_n_in = 1'b1;
        quiet = 1'b1;
        repeat (4) begin @(posedge clk_in); #1; if (sum_valid_out !== 1'b0) quiet = 1'b0; end
        n_tests++; if (!quiet) begin n_fail++; $display("FAIL midrst_no_sum got valid=1 want 0"); end
        drive_pair(2, 2, 1, ok);
        wait_sum(ok);
        get_exp(e);
        n_tests++; if (!ok || sum_out !== e.sum) begin n_fail++; $display("FAIL midrst_next got %0d want %0d", sum_out, $signed(e.sum)); end
        @(posedge clk_in); #1;
    endtask

    task automatic test_back_to_back();
        exp_t e;
        sum_ready_in = 1'b1;
        fork
            begin
                bit ok;
                drive_pair(1, 2, 0, ok);
                drive_pair(3, 4, 1, ok);
                drive_pair(-5, 6, 1, ok);
            end
            begin
                bit got;
                for (int k = 0; k < 2; k++) begin
                    wait_sum(got);
                    get_exp(e);
                    n_tests++; if (!got || sum_out !== e.sum) begin n_fail++; $display("FAIL b2b_sum%0d got %0d want %0d", k, sum_out, $signed(e.sum)); end
                    @(posedge clk_in); #1;
                end
            end
        join
    endtask

`ifdef NEURON_MAC_BIAS_EN
    task automatic test_bias();
        bit ok;
        exp_t e;
        sum_ready_in = 1'b1;
        m_bias = -10;
        drive_pair(2, 3, 0, ok);
        m_bias = 0;
        drive_pair(1, 1, 1, ok);
        wait_sum(ok);
        get_exp(e);
        n_tests++; if (!ok || sum_out !== e.sum) begin n_fail++; $display("FAIL bias_sum got %0d want %0d", sum_out, $signed(e.sum)); end
        @(posedge clk_in); #1;
    endtask
`endif

    initial begin
        rst_n_in     = 1'b0;
        data_in      = '0;
        weight_in    = '0;
        in_valid_in  = 1'b0;
        in_last_in   = 1'b0;
        sum_ready_in = 1'b0;
`ifdef NEURON_MAC_BIAS_EN
        bias_in      = '0;
`endif
        test_reset();
        test_basic();
        test_single();
        test_overrun();
        test_wrap();
        test_reset_mid();
        test_back_to_back();
`ifdef NEURON_MAC_BIAS_EN
        test_bias();
`endif
        n_tests++; if (sb.size() != 0) begin n_fail++; $display("FAIL scoreboard_left got %0d want 0", sb.size()); end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
